// File: rtl/tlul_pkg.sv
// Shared TileLink-UL opcodes, the buffered D-channel response record and the
// PutFullData lane-mask helper used by the SRAM responder.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Entry fields are sized for the widest supported bus and source ID;
    // each instance uses the low bits.
    localparam int TL_DW_MAX = 64;
    localparam int TL_SW_MAX = 16;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           size;
        logic [TL_SW_MAX-1:0] source;
        logic                 denied;
        logic [TL_DW_MAX-1:0] data;
    } tl_d_entry_t;

    // Byte lanes a PutFullData of 2^size bytes at the given word offset must enable.
    function automatic logic [7:0] full_mask(input logic [2:0] size, input logic [2:0] addr_lsbs);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h0F;
            3'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m << addr_lsbs;
    endfunction

endpackage

// File: rtl/tlul_resp_fifo2.sv
// Two-entry response FIFO holding decoded D-channel responses; the head entry
// drives the D channel directly so it stays stable while stalled.
module tlul_resp_fifo2
    import tlul_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  tl_d_entry_t i_push_data,
    input  logic        i_pop,
    output tl_d_entry_t o_head,
    output logic [1:0]  o_count,
    output logic        o_full,
    output logic        o_empty
);

    tl_d_entry_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, 1-bit wrapping pointers and occupancy count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tlul_sram_responder.sv
// TileLink-UL manager endpoint: decodes single-beat Get/Put requests against a
// local word-addressed SRAM and queues responses in a 2-entry buffer.
module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int                ADDR_W    = 25,
    parameter int                DATA_W    = 32,
    parameter int                SOURCE_W  = 7,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [2:0]            a_size,
    input  logic [SOURCE_W-1:0]   a_source,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_mask,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [1:0]            d_param,
    output logic [2:0]            d_size,
    output logic [SOURCE_W-1:0]   d_source,
    output logic                  d_sink,
    output logic                  d_denied,
    output logic                  d_corrupt,
    output logic [DATA_W-1:0]     d_data
);

    localparam int         BYTES = DATA_W / 8;
    localparam int         LG    = $clog2(BYTES);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam int         HI    = LG + IDX_W;
    localparam logic [2:0] LG3   = 3'(LG);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_is_get;
    logic              w_is_put_full;
    logic              w_is_put;
    logic              w_bad_op;
    logic              w_bad_size;
    logic [LG-1:0]     w_align_mask;
    logic              w_misaligned;
    logic              w_out_range;
    logic [2:0]        w_lsbs;
    logic [7:0]        w_full_mask;
    logic [7:0]        w_mask8;
    logic              w_bad_mask;
    logic              w_denied;
    logic              w_a_fire;
    logic              w_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rdata;
    tl_d_entry_t       w_entry;
    tl_d_entry_t       w_head;
    logic [1:0]        w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_unused;

    // Request decode and denial checks.
    always_comb begin
        w_is_get      = (a_opcode == GET);
        w_is_put_full = (a_opcode == PUT_FULL);
        w_is_put      = w_is_put_full | (a_opcode == PUT_PARTIAL);
        w_bad_op      = ~(w_is_get | w_is_put);
        w_bad_size    = (a_size > LG3);
        w_align_mask  = ~({LG{1'b1}} << a_size);
        w_misaligned  = |(a_address[LG-1:0] & w_align_mask);
        // BASE_ADDR is aligned to the SRAM span, so range reduces to an upper-bit match.
        w_out_range   = (a_address[ADDR_W-1:HI] != BASE_ADDR[ADDR_W-1:HI]);
        w_lsbs        = 3'b000;
        w_lsbs[LG-1:0] = a_address[LG-1:0];
        w_full_mask   = full_mask(a_size, w_lsbs);
        w_mask8       = 8'h00;
        w_mask8[BYTES-1:0] = a_mask;
        w_bad_mask    = w_is_put_full & (w_mask8 != w_full_mask);
        w_denied      = w_bad_op | (a_param != 3'd0) | w_bad_size | w_misaligned
                      | w_out_range | w_bad_mask;
    end

    assign w_a_fire = a_valid & a_ready;
    assign w_we     = w_a_fire & reset_n & w_is_put & ~w_denied;
    assign w_idx    = a_address[HI-1:LG];
    assign w_rdata  = r_mem[w_idx];

    // Response entry captured at the A fire edge.
    always_comb begin
        w_entry                        = '0;
        w_entry.opcode                 = w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        w_entry.size                   = a_size;
        w_entry.source[SOURCE_W-1:0]   = a_source;
        w_entry.denied                 = w_denied;
        if (w_is_get && !w_denied) begin
            w_entry.data[DATA_W-1:0] = w_rdata;
        end else begin
            w_entry.data = '0;
        end
    end

    // Byte-masked SRAM write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BYTES; i++) begin
            if (w_we && a_mask[i]) begin
                r_mem[w_idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    tlul_resp_fifo2 u_resp_fifo (
        .i_clk       (clock),
        .i_rst_n     (reset_n),
        .i_push      (w_a_fire),
        .i_push_data (w_entry),
        .i_pop       (d_ready),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign a_ready   = ~w_full;
    assign d_valid   = ~w_empty;
    assign d_opcode  = w_head.opcode;
    assign d_param   = 2'b00;
    assign d_size    = w_head.size;
    assign d_source  = w_head.source[SOURCE_W-1:0];
    assign d_sink    = 1'b0;
    assign d_denied  = w_head.denied;
    assign d_corrupt = w_head.denied & (w_head.opcode == ACCESS_ACK_DATA);
    assign d_data    = w_head.data[DATA_W-1:0];

    // Entry bits above the configured widths are always zero.
    assign w_unused  = ^{w_head.source, w_head.data, w_count};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed self-checking bench for tlul_sram_responder (32-bit bus, base 0x400).
module tb_tlul_sram_responder;

    localparam logic [24:0] BASE = 25'h400;

    logic        clock;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [6:0]  a_source;
    logic [24:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [6:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [24:0] b_addr [4];
    logic [31:0] b_exp  [4];

    tlul_sram_responder #(
        .ADDR_W(25), .DATA_W(32), .SOURCE_W(7), .DEPTH(256), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .d_data(d_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                           input logic [6:0] src, input logic [24:0] addr,
                           input logic [3:0] mask, input logic [31:0] data);
        a_opcode  = op;
        a_param   = prm;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
    endtask

    // Present a request, wait (bounded) for a_ready, fire it, return 1 time unit after the fire edge.
    task automatic send(input string tag, input logic [2:0] op, input logic [2:0] prm,
                        input logic [2:0] sz, input logic [6:0] src, input logic [24:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
        int w;
        set_req(op, prm, sz, src, addr, mask, data);
        w = 0;
        while (!a_ready && w < 20) begin
            tick();
            w++;
        end
        if (!a_ready) check_eq({tag, "_a_ready_timeout"}, {63'd0, a_ready}, 64'd1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [2:0] op, input logic [6:0] src,
                            input logic den, input logic [31:0] data);
        check_eq({tag, "_d_valid"},   {63'd0, d_valid},   64'd1);
        check_eq({tag, "_d_opcode"},  {61'd0, d_opcode},  {61'd0, op});
        check_eq({tag, "_d_source"},  {57'd0, d_source},  {57'd0, src});
        check_eq({tag, "_d_denied"},  {63'd0, d_denied},  {63'd0, den});
        check_eq({tag, "_d_corrupt"}, {63'd0, d_corrupt}, {63'd0, den & (op == 3'd1)});
        check_eq({tag, "_d_data"},    {32'd0, d_data},    {32'd0, data});
    endtask

    initial begin
        reset_n = 1'b0;
        d_ready = 1'b0;
        set_req(3'd0, 3'd0, 3'd0, 7'd0, 25'd0, 4'h0, 32'd0);
        a_valid = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_eq("rst_d_valid", {63'd0, d_valid}, 64'd0);
        check_eq("rst_a_ready", {63'd0, a_ready}, 64'd1);
        check_eq("rst_d_data", {32'd0, d_data}, 64'd0);
        check_eq("rst_d_source", {57'd0, d_source}, 64'd0);

        // Write then read back, full and partial puts.
        d_ready = 1'b1;
        send("pf", 3'd0, 3'd0, 3'd2, 7'd5, BASE + 25'h10, 4'hF, 32'hDEADBEEF);
        chk_resp("pf_ack", 3'd0, 7'd5, 1'b0, 32'h0);
        send("get1", 3'd4, 3'd0, 3'd2, 7'd6, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("get1", 3'd1, 7'd6, 1'b0, 32'hDEADBEEF);
        send("pp", 3'd1, 3'd0, 3'd2, 7'd7, BASE + 25'h10, 4'h3, 32'h0000CAFE);
        chk_resp("pp_ack", 3'd0, 7'd7, 1'b0, 32'h0);
        send("get2", 3'd4, 3'd0, 3'd2, 7'd8, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("get2", 3'd1, 7'd8, 1'b0, 32'hDEADCAFE);
        send("w20", 3'd0, 3'd0, 3'd2, 7'd1, BASE + 25'h20, 4'hF, 32'h11111111);
        chk_resp("w20", 3'd0, 7'd1, 1'b0, 32'h0);
        send("w24", 3'd0, 3'd0, 3'd2, 7'd2, BASE + 25'h24, 4'hF, 32'h22222222);
        chk_resp("w24", 3'd0, 7'd2, 1'b0, 32'h0);
        send("w28", 3'd0, 3'd0, 3'd2, 7'd3, BASE + 25'h28, 4'hF, 32'h33333333);
        chk_resp("w28", 3'd0, 7'd3, 1'b0, 32'h0);
        tick();
        check_eq("idle1_d_valid", {63'd0, d_valid}, 64'd0);

        // Backpressure: buffer fills after two fires, third waits for first pop.
        d_ready = 1'b0;
        send("st0", 3'd4, 3'd0, 3'd2, 7'd10, BASE + 25'h20, 4'hF, 32'h0);
        check_eq("st_a_ready_cnt1", {63'd0, a_ready}, 64'd1);
        send("st1", 3'd4, 3'd0, 3'd2, 7'd11, BASE + 25'h24, 4'hF, 32'h0);
        check_eq("st_a_ready_cnt2", {63'd0, a_ready}, 64'd0);
        set_req(3'd4, 3'd0, 3'd2, 7'd12, BASE + 25'h28, 4'hF, 32'h0);
        chk_resp("st_head", 3'd1, 7'd10, 1'b0, 32'h11111111);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("st_hold_a_ready", {63'd0, a_ready}, 64'd0);
            chk_resp("st_hold", 3'd1, 7'd10, 1'b0, 32'h11111111);
        end
        d_ready = 1'b1;
        tick();
        check_eq("st_third_accept", {63'd0, a_ready}, 64'd1);
        chk_resp("st_pop1", 3'd1, 7'd11, 1'b0, 32'h22222222);
        tick();
        a_valid = 1'b0;
        chk_resp("st_third", 3'd1, 7'd12, 1'b0, 32'h33333333);
        tick();
        check_eq("idle2_d_valid", {63'd0, d_valid}, 64'd0);

        // Boundaries and denial cases.
        send("last_w", 3'd0, 3'd0, 3'd2, 7'd23, BASE + 25'h3FC, 4'hF, 32'h0A5A5A5A);
        chk_resp("last_w", 3'd0, 7'd23, 1'b0, 32'h0);
        send("last_r", 3'd4, 3'd0, 3'd2, 7'd24, BASE + 25'h3FC, 4'hF, 32'h0);
        chk_resp("last_r", 3'd1, 7'd24, 1'b0, 32'h0A5A5A5A);
        send("oor", 3'd4, 3'd0, 3'd2, 7'd20, BASE + 25'h400, 4'hF, 32'h0);
        chk_resp("oor", 3'd1, 7'd20, 1'b1, 32'h0);
        send("op2", 3'd2, 3'd0, 3'd2, 7'd21, BASE + 25'h10, 4'hF, 32'hFFFFFFFF);
        chk_resp("op2", 3'd0, 7'd21, 1'b1, 32'h0);
        send("mis", 3'd4, 3'd0, 3'd2, 7'd22, BASE + 25'h12, 4'hF, 32'h0);
        chk_resp("mis", 3'd1, 7'd22, 1'b1, 32'h0);
        send("prm", 3'd4, 3'd1, 3'd2, 7'd25, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("prm", 3'd1, 7'd25, 1'b1, 32'h0);
        send("sz3", 3'd4, 3'd0, 3'd3, 7'd26, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("sz3", 3'd1, 7'd26, 1'b1, 32'h0);
        send("badmask", 3'd0, 3'd0, 3'd2, 7'd27, BASE + 25'h10, 4'h3, 32'hFFFFFFFF);
        chk_resp("badmask", 3'd0, 7'd27, 1'b1, 32'h0);
        send("pp_mis", 3'd1, 3'd0, 3'd1, 7'd28, BASE + 25'h11, 4'h2, 32'hFFFFFFFF);
        chk_resp("pp_mis", 3'd0, 7'd28, 1'b1, 32'h0);
        send("below", 3'd0, 3'd0, 3'd2, 7'd29, BASE - 25'h4, 4'hF, 32'hFFFFFFFF);
        chk_resp("below", 3'd0, 7'd29, 1'b1, 32'h0);
        send("unchg", 3'd4, 3'd0, 3'd2, 7'd30, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("unchg", 3'd1, 7'd30, 1'b0, 32'hDEADCAFE);
        send("pf_half", 3'd0, 3'd0, 3'd1, 7'd31, BASE + 25'h12, 4'hC, 32'hBEEF0000);
        chk_resp("pf_half", 3'd0, 7'd31, 1'b0, 32'h0);
        send("get_half", 3'd4, 3'd0, 3'd2, 7'd32, BASE + 25'h10, 4'hF, 32'h0);
        chk_resp("get_half", 3'd1, 7'd32, 1'b0, 32'hBEEFCAFE);
        send("get_b3", 3'd4, 3'd0, 3'd0, 7'd33, BASE + 25'h13, 4'h8, 32'h0);
        chk_resp("get_b3", 3'd1, 7'd33, 1'b0, 32'hBEEFCAFE);
        tick();
        check_eq("idle3_d_valid", {63'd0, d_valid}, 64'd0);

        // Back-to-back Gets: one response per cycle, a_ready never drops.
        b_addr[0] = BASE + 25'h20; b_exp[0] = 32'h11111111;
        b_addr[1] = BASE + 25'h24; b_exp[1] = 32'h22222222;
        b_addr[2] = BASE + 25'h28; b_exp[2] = 32'h33333333;
        b_addr[3] = BASE + 25'h10; b_exp[3] = 32'hBEEFCAFE;
        set_req(3'd4, 3'd0, 3'd2, 7'd40, b_addr[0], 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("b2b_a_ready", {63'd0, a_ready}, 64'd1);
            chk_resp("b2b", 3'd1, 7'(40 + i), 1'b0, b_exp[i]);
            if (i < 3) set_req(3'd4, 3'd0, 3'd2, 7'(41 + i), b_addr[i+1], 4'hF, 32'h0);
            else a_valid = 1'b0;
        end
        tick();
        check_eq("idle4_d_valid", {63'd0, d_valid}, 64'd0);

        // Reset while full; SRAM contents survive.
        d_ready = 1'b0;
        send("rf0", 3'd4, 3'd0, 3'd2, 7'd50, BASE + 25'h20, 4'hF, 32'h0);
        send("rf1", 3'd4, 3'd0, 3'd2, 7'd51, BASE + 25'h24, 4'hF, 32'h0);
        check_eq("rf_full_a_ready", {63'd0, a_ready}, 64'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("rf_d_valid", {63'd0, d_valid}, 64'd0);
        check_eq("rf_a_ready", {63'd0, a_ready}, 64'd1);
        d_ready = 1'b1;
        send("rf_get", 3'd4, 3'd0, 3'd2, 7'd52, BASE + 25'h24, 4'hF, 32'h0);
        chk_resp("rf_get", 3'd1, 7'd52, 1'b0, 32'h22222222);
        tick();
        check_eq("idle5_d_valid", {63'd0, d_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
